// File: rtl/rob_drain_ctrl.sv
// rob_drain_ctrl: reorder-buffer controller for a DEPTH x DATA_W RAM.
// Hands out in-order tags, writes out-of-order responses at their tag
// address, and drains lines strictly in tag order through a small skid
// FIFO that absorbs the RAM read latency.
// Optional: define ROB_PERF_CNT_EN to add perf_hol_cycles / perf_stall_cycles.
module rob_drain_ctrl #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [ADDR_W-1:0] alloc_tag,
  input  logic              rsp_valid,
  input  logic [ADDR_W-1:0] rsp_tag,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   occupancy,
  output logic              err_rsp
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_hol_cycles,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam int unsigned DEPTH   = 2**ADDR_W;
  localparam int unsigned SKID    = RAM_LAT + 2;
  localparam int unsigned SKID_IW = $clog2(SKID);
  localparam int unsigned SKID_CW = $clog2(SKID + 1);
  localparam int unsigned LAT_CW  = $clog2(RAM_LAT + 1);
  localparam int unsigned CRED_W  = SKID_CW + 1;

  localparam logic [ADDR_W-1:0]  PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]    OCC_ONE  = (ADDR_W+1)'(1);
  localparam logic [SKID_CW-1:0] CNT_ONE  = SKID_CW'(1);
  localparam logic [SKID_IW-1:0] IDX_LAST = SKID_IW'(SKID - 1);
  localparam logic [CRED_W-1:0]  CRED_MAX = CRED_W'(SKID);

  logic [ADDR_W-1:0]  alloc_ptr;
  logic [ADDR_W-1:0]  head_ptr;
  logic [ADDR_W-1:0]  drain_ptr;
  logic [DEPTH-1:0]   valid_q;
  logic [RAM_LAT-1:0] rd_pipe;
  logic [DATA_W-1:0]  skid_mem [SKID];
  logic [SKID_IW-1:0] skid_wr_idx;
  logic [SKID_IW-1:0] skid_rd_idx;
  logic [SKID_CW-1:0] skid_cnt;
  logic [LAT_CW-1:0]  inflight;
  logic [CRED_W-1:0]  credit_used;
  logic [ADDR_W-1:0]  rsp_off;
  logic [ADDR_W-1:0]  drained;
  logic               issue;
  logic               capture;
  logic               pop;
  logic               rsp_ok;

  function automatic logic [SKID_IW-1:0] skid_next(input logic [SKID_IW-1:0] idx);
    return (idx == IDX_LAST) ? '0 : idx + SKID_IW'(1);
  endfunction

  assign alloc_gnt   = alloc_req && !occupancy[ADDR_W];
  assign alloc_tag   = alloc_ptr;
  assign ram_rd_addr = drain_ptr;

  // Count reads issued to the RAM whose data has not yet been captured.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RAM_LAT; i++)
      inflight = inflight + LAT_CW'(rd_pipe[i]);
  end

  // Reads in flight plus lines already buffered may never exceed the skid
  // depth, so the FIFO cannot overflow even when the consumer stalls.
  assign credit_used = CRED_W'(inflight) + CRED_W'(skid_cnt);
  assign issue       = valid_q[drain_ptr] && (credit_used < CRED_MAX);
  assign capture     = rd_pipe[RAM_LAT-1];

  assign out_valid = (skid_cnt != '0);
  assign out_data  = skid_mem[skid_rd_idx];
  assign pop       = out_valid && out_ready;

  // A response is legal only for an allocated tag that has not been read out
  // yet, whose valid bit is clear and which is not already queued for write.
  assign rsp_off = rsp_tag - head_ptr;
  assign drained = drain_ptr - head_ptr;
  assign rsp_ok  = ({1'b0, rsp_off} < occupancy) && (rsp_off >= drained) &&
                   !valid_q[rsp_tag] && !(ram_wr_en && (ram_wr_addr == rsp_tag));

  // Tag pointers and occupancy (tags allocated, not yet captured).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      head_ptr  <= '0;
      drain_ptr <= '0;
      occupancy <= '0;
    end else begin
      if (alloc_gnt) alloc_ptr <= alloc_ptr + PTR_ONE;
      if (capture)   head_ptr  <= head_ptr + PTR_ONE;
      if (issue)     drain_ptr <= drain_ptr + PTR_ONE;
      case ({alloc_gnt, capture})
        2'b10:   occupancy <= occupancy + OCC_ONE;
        2'b01:   occupancy <= occupancy - OCC_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Register legal responses onto the RAM write port; flag illegal ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      err_rsp     <= 1'b0;
    end else begin
      ram_wr_en <= rsp_valid && rsp_ok;
      if (rsp_valid && rsp_ok) begin
        ram_wr_addr <= rsp_tag;
        ram_wr_data <= rsp_data;
      end
      if (rsp_valid && !rsp_ok) err_rsp <= 1'b1;
    end
  end

  // Valid bitmap: set when the RAM commits the write, cleared on read issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (issue)     valid_q[drain_ptr]   <= 1'b0;
      if (ram_wr_en) valid_q[ram_wr_addr] <= 1'b1;
    end
  end

  // Read-latency tracker: bit RAM_LAT-1 marks ram_rd_data valid this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= issue;
      for (int unsigned i = 1; i < RAM_LAT; i++)
        rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  // Skid FIFO holding returned lines until the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SKID; i++)
        skid_mem[i] <= '0;
      skid_wr_idx <= '0;
      skid_rd_idx <= '0;
      skid_cnt    <= '0;
    end else begin
      if (capture) begin
        skid_mem[skid_wr_idx] <= ram_rd_data;
        skid_wr_idx           <= skid_next(skid_wr_idx);
      end
      if (pop) skid_rd_idx <= skid_next(skid_rd_idx);
      case ({capture, pop})
        2'b10:   skid_cnt <= skid_cnt + CNT_ONE;
        2'b01:   skid_cnt <= skid_cnt - CNT_ONE;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

`ifdef ROB_PERF_CNT_EN
  // Saturating counters for head-of-line wait and consumer backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hol_cycles   <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if ((occupancy != '0) && !valid_q[drain_ptr] && (inflight == '0) &&
          (perf_hol_cycles != '1))
        perf_hol_cycles <= perf_hol_cycles + 32'd1;
      if (out_valid && !out_ready && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_drain_ctrl.sv
// Directed testbench for rob_drain_ctrl with a behavioural RAM model.
module tb_rob_drain_ctrl;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned DATA_W  = 512;
  localparam int unsigned RAM_LAT = 2;
  localparam int unsigned DEPTH   = 4096;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alloc_req;
  logic              alloc_gnt;
  logic [ADDR_W-1:0] alloc_tag;
  logic              rsp_valid;
  logic [ADDR_W-1:0] rsp_tag;
  logic [DATA_W-1:0] rsp_data;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [ADDR_W:0]   occupancy;
  logic              err_rsp;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]       perf_hol_cycles;
  logic [31:0]       perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  rob_drain_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .err_rsp(err_rsp)
`ifdef ROB_PERF_CNT_EN
    , .perf_hol_cycles(perf_hol_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  // RAM model: synchronous write, read data RAM_LAT cycles after address.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_pipe [RAM_LAT];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    rd_pipe[0] <= mem[ram_rd_addr];
    for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rd_data = rd_pipe[RAM_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: transfers and RAM writes, sampled mid-cycle.
  logic [DATA_W-1:0] got_q[$];
  int                got_cyc[$];
  int                wr_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_cyc.push_back(cyc);
      end
      if (ram_wr_en) wr_cnt++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input int unsigned tag, input int unsigned salt);
    return {16{salt[19:0], tag[11:0]}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; alloc_req = 1'b0; rsp_valid = 1'b0;
    rsp_tag = '0; rsp_data = '0; out_ready = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic alloc_n(input int n, input int unsigned first);
    for (int i = 0; i < n; i++) begin
      alloc_req = 1'b1;
      #1;
      chk("alloc_gnt", alloc_gnt, 1);
      chk("alloc_tag", alloc_tag, (first + i) % DEPTH);
      tick();
    end
    alloc_req = 1'b0;
  endtask

  task automatic respond(input int unsigned tag, input int unsigned salt);
    rsp_valid = 1'b1;
    rsp_tag   = ADDR_W'(tag);
    rsp_data  = mk(tag, salt);
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic chk_lines(input string tag, input int base, input int n, input int unsigned salt);
    chk({tag, "_count"}, got_q.size() - base, n);
    if (got_q.size() - base == n)
      for (int i = 0; i < n; i++) chk({tag, "_data"}, got_q[base+i], mk(i, salt));
  endtask

  initial begin
    int base, c0, w0, ng, last;
    logic [DATA_W-1:0] held;

    // Reset values
    rst_n = 1'b0; alloc_req = 1'b0; rsp_valid = 1'b0;
    rsp_tag = '0; rsp_data = '0; out_ready = 1'b0;
    #2;
    chk("rst_gnt", alloc_gnt, 0);
    chk("rst_tag", alloc_tag, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_err", err_rsp, 0);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_rd_addr", ram_rd_addr, 0);
    do_reset();

    // 1: in-order responses, latency and streaming
    out_ready = 1'b1;
    alloc_n(4, 0);
    chk("t1_occ_alloc", occupancy, 4);
    base = got_q.size();
    c0 = cyc;
    for (int i = 0; i < 4; i++) respond(i, 1);
    ticks(12);
    chk_lines("t1", base, 4, 1);
    if (got_q.size() - base == 4)
      for (int i = 0; i < 4; i++) chk("t1_cycle", got_cyc[base+i], c0 + 3 + RAM_LAT + i);
    chk("t1_occ_end", occupancy, 0);

    // 2: reverse-order responses, head-of-line blocking
    do_reset();
    out_ready = 1'b1;
    alloc_n(8, 0);
    base = got_q.size();
    for (int i = 7; i >= 1; i--) respond(i, 6);
    ticks(10);
    chk("t2_blocked", got_q.size() - base, 0);
    c0 = cyc;
    respond(0, 6);
    ticks(20);
    chk_lines("t2", base, 8, 6);
    if (got_q.size() - base == 8) begin
      chk("t2_first_cycle", got_cyc[base], c0 + 3 + RAM_LAT);
      chk("t2_b2b", got_cyc[base+7] - got_cyc[base], 7);
    end

    // 3: fill all tags, full stall, wrap
    do_reset();
    out_ready = 1'b1;
    ng = 0; last = -1;
    alloc_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      if (alloc_gnt) begin ng++; last = int'(alloc_tag); end
      tick();
    end
    #1;
    chk("t3_grants", ng, DEPTH);
    chk("t3_last_tag", last, DEPTH - 1);
    chk("t3_occ_full", occupancy, DEPTH);
    chk("t3_gnt_full", alloc_gnt, 0);
    alloc_req = 1'b0;
    base = got_q.size();
    respond(0, 3);
    ticks(10);
    chk_lines("t3", base, 1, 3);
    chk("t3_occ_drain", occupancy, DEPTH - 1);
    alloc_req = 1'b1;
    #1;
    chk("t3_gnt_wrap", alloc_gnt, 1);
    chk("t3_tag_wrap", alloc_tag, 0);
    tick();
    alloc_req = 1'b0;
    chk("t3_occ_refull", occupancy, DEPTH);

    // 4: consumer backpressure
    do_reset();
    out_ready = 1'b0;
    alloc_n(16, 0);
    for (int i = 0; i < 16; i++) respond(i, 2);
    ticks(10);
    chk("t4_valid", out_valid, 1);
    chk("t4_head", out_data, mk(0, 2));
    chk("t4_reads", ram_rd_addr, RAM_LAT + 2);
    chk("t4_occ", occupancy, 16 - (RAM_LAT + 2));
    held = out_data;
    ticks(5);
    chk("t4_stable", out_data, held);
    chk("t4_reads_hold", ram_rd_addr, RAM_LAT + 2);
    base = got_q.size();
    out_ready = 1'b1;
    ticks(30);
    chk_lines("t4", base, 16, 2);
    chk("t4_occ_end", occupancy, 0);

    // 5: illegal responses
    do_reset();
    out_ready = 1'b1;
    alloc_n(8, 0);
    chk("t5_err_clean", err_rsp, 0);
    w0 = wr_cnt;
    respond(5, 7);
    ticks(3);
    chk("t5_err_first", err_rsp, 0);
    respond(5, 8);
    ticks(3);
    chk("t5_err_dup", err_rsp, 1);
    chk("t5_wr_dup", wr_cnt - w0, 1);
    respond(100, 9);
    ticks(3);
    chk("t5_wr_unalloc", wr_cnt - w0, 1);
    base = got_q.size();
    for (int i = 0; i < 8; i++) if (i != 5) respond(i, 7);
    ticks(15);
    chk_lines("t5", base, 8, 7);
    chk("t5_err_sticky", err_rsp, 1);
    chk("t5_occ_end", occupancy, 0);

    // 6: asynchronous reset mid-drain
    do_reset();
    out_ready = 1'b1;
    alloc_n(8, 0);
    for (int i = 0; i < 6; i++) respond(i, 4);
    chk("t6_pre_valid", out_valid, 1);
    chk("t6_pre_wr", ram_wr_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_occ", occupancy, 0);
    chk("t6_wr_en", ram_wr_en, 0);
    ticks(2);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    alloc_n(1, 0);
    base = got_q.size();
    respond(0, 5);
    ticks(10);
    chk_lines("t6", base, 1, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
